// File: rtl/cd_host_pkg.sv
// cd_host_pkg: shared constants for the CD-block host interface.
//   - register offsets in the CS2 window ({AA[15:1],0})
//   - CMOK bit position in HIRQ
//   - default command/response reset image
//   - byte-lane merge helper used by every writable register
package cd_host_pkg;

    localparam logic [15:0] OFS_DTR      = 16'h0000;
    localparam logic [15:0] OFS_HIRQ     = 16'h0008;
    localparam logic [15:0] OFS_HIRQMASK = 16'h000C;
    localparam logic [15:0] OFS_CR0      = 16'h0018;
    localparam int          CR_STRIDE    = 4;

    localparam int CMOK_BIT = 0;

    localparam logic [63:0] CR_INIT_DEFAULT = 64'h434B_4C4F_4442_0043;

    // Replace only the byte lanes whose strobe is active.
    function automatic logic [15:0] lane_merge(input logic [15:0] old_val,
                                               input logic [15:0] data,
                                               input logic        lo,
                                               input logic        hi);
        return {hi ? data[15:8] : old_val[15:8], lo ? data[7:0] : old_val[7:0]};
    endfunction

endpackage

// File: rtl/cd_dt_fifo.sv
// cd_dt_fifo: data-transfer FIFO behind the DTR register.
//   CLK, RST_N : clock, async active-low reset
//   en         : clock enable; nothing moves without it
//   push, din  : write side (dropped when full unless a pop frees a slot)
//   pop        : read side (ignored when empty)
//   head       : current oldest word (undefined content when empty)
//   count      : occupancy 0..DEPTH
//   full/empty : status flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module cd_dt_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     en,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    logic         do_push, do_pop;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign count = wp - rp;
    assign head  = mem[rp[AW-1:0]];

    // A pop in the same cycle frees the slot the push needs when full.
    assign do_pop  = en && pop && !empty;
    assign do_push = en && push && (!full || do_pop);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cd_host_if.sv
// cd_host_if: CD-block host register window on the A-bus CS2 space.
//   CLK, RST_N, CE_R        : clock, async active-low reset, clock enable
//   ACS2_N, AA, ADO, ADI    : A-bus chip select, address [25:1], write/read data
//   AWRL_N, AWRU_N, ARD_N   : low/high byte write strobes, read strobe
//   IRQ_N                   : registered host interrupt (active low)
//   CMD_VALID/CMD_CR/CMD_ACK: command handoff to the CD controller
//   RSP_VALID/RSP_CR        : response load from the CD controller
//   HIRQ_SET                : per-bit interrupt set pulses
//   DT_WR/DT_DATA/DT_FULL/DT_COUNT : DTR FIFO fill side
module cd_host_if
    import cd_host_pkg::*;
#(
    parameter int                   CR_NUM     = 4,
    parameter int                   IRQ_W      = 16,
    parameter int                   FIFO_DEPTH = 16,
    parameter logic [9:0]           BASE_HI    = 10'h189,
    parameter logic [16*CR_NUM-1:0] CR_INIT    = (16*CR_NUM)'(CR_INIT_DEFAULT)
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          CE_R,
    input  logic                          ACS2_N,
    input  logic [25:1]                   AA,
    input  logic [15:0]                   ADO,
    output logic [15:0]                   ADI,
    input  logic                          AWRL_N,
    input  logic                          AWRU_N,
    input  logic                          ARD_N,
    output logic                          IRQ_N,
    output logic                          CMD_VALID,
    output logic [16*CR_NUM-1:0]          CMD_CR,
    input  logic                          CMD_ACK,
    input  logic                          RSP_VALID,
    input  logic [16*CR_NUM-1:0]          RSP_CR,
    input  logic [IRQ_W-1:0]              HIRQ_SET,
    input  logic                          DT_WR,
    input  logic [15:0]                   DT_DATA,
    output logic                          DT_FULL,
    output logic [$clog2(FIFO_DEPTH):0]   DT_COUNT
);

    // ---------------- decode ----------------
    logic              sel;
    logic [15:0]       ofs;
    logic              hit_dtr, hit_hirq, hit_mask;
    logic [CR_NUM-1:0] cr_hit;

    assign sel      = !ACS2_N && (AA[25:16] == BASE_HI);
    assign ofs      = {AA[15:1], 1'b0};
    assign hit_dtr  = (ofs == OFS_DTR);
    assign hit_hirq = (ofs == OFS_HIRQ);
    assign hit_mask = (ofs == OFS_HIRQMASK);

    always_comb begin
        cr_hit = '0;
        for (int i = 0; i < CR_NUM; i++)
            cr_hit[i] = (ofs == OFS_CR0 + 16'(CR_STRIDE * i));
    end

    // ---------------- strobe edge detection ----------------
    logic lo, hi, wr_act, wr_q, commit;
    logic rd_act, rd_q, pop;

    assign lo     = !AWRL_N;
    assign hi     = !AWRU_N;
    assign wr_act = sel && (lo || hi);
    assign commit = CE_R && wr_act && !wr_q;

    // Pop once when the read strobe releases after a DTR read.
    assign rd_act = sel && hit_dtr && !ARD_N;
    assign pop    = rd_q && ARD_N;

    // ---------------- register state ----------------
    logic [IRQ_W-1:0]             hirq, mask, hirq_nx;
    logic [CR_NUM-1:0][15:0]      rsp, shadow, shadow_nx, cmd;
    logic                         cmd_valid, irq_q;
    logic                         cr_wr, last_wr;

    // Command registers are frozen while a command is outstanding.
    assign cr_wr   = commit && (|cr_hit) && !cmd_valid;
    assign last_wr = cr_wr && cr_hit[CR_NUM-1];

    always_comb begin
        shadow_nx = shadow;
        for (int i = 0; i < CR_NUM; i++)
            if (cr_wr && cr_hit[i])
                shadow_nx[i] = lane_merge(shadow[i], ADO, lo, hi);

        // Clears first, sets last: a set in the same cycle always wins.
        hirq_nx = hirq;
        if (commit && hit_hirq)
            hirq_nx = hirq & IRQ_W'({hi ? ADO[15:8] : 8'hFF, lo ? ADO[7:0] : 8'hFF});
        if (last_wr)
            hirq_nx[CMOK_BIT] = 1'b0;
        hirq_nx = hirq_nx | HIRQ_SET;
        if (RSP_VALID)
            hirq_nx[CMOK_BIT] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            // Strobe history resets to "busy" so a write still held across
            // reset release needs a fresh strobe edge before it can commit.
            wr_q      <= 1'b1;
            rd_q      <= 1'b0;
            hirq      <= '1;
            mask      <= '1;
            rsp       <= CR_INIT;
            shadow    <= '0;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            irq_q     <= 1'b0;
        end else if (CE_R) begin
            wr_q   <= wr_act;
            rd_q   <= rd_act;
            hirq   <= hirq_nx;
            shadow <= shadow_nx;
            if (commit && hit_mask)
                mask <= IRQ_W'(lane_merge(16'(mask), ADO, lo, hi));
            if (RSP_VALID)
                rsp <= RSP_CR;
            if (last_wr) begin
                cmd       <= shadow_nx;
                cmd_valid <= 1'b1;
            end else if (CMD_ACK) begin
                cmd_valid <= 1'b0;
            end
            irq_q <= ~|(hirq & mask);
        end
    end

    // ---------------- DTR FIFO ----------------
    logic [15:0] dt_head;
    logic        dt_empty;

    cd_dt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (16)
    ) u_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .en    (CE_R),
        .push  (DT_WR),
        .din   (DT_DATA),
        .pop   (pop),
        .head  (dt_head),
        .count (DT_COUNT),
        .full  (DT_FULL),
        .empty (dt_empty)
    );

    // ---------------- read mux ----------------
    logic [15:0] rdata;

    always_comb begin
        rdata = '0;
        if (hit_dtr)
            rdata = dt_empty ? 16'h0000 : dt_head;
        else if (hit_hirq)
            rdata = 16'(hirq);
        else if (hit_mask)
            rdata = 16'(mask);
        for (int i = 0; i < CR_NUM; i++)
            if (cr_hit[i]) rdata = rsp[i];
    end

    assign ADI       = sel ? rdata : 16'h0000;
    assign IRQ_N     = irq_q;
    assign CMD_VALID = cmd_valid;
    assign CMD_CR    = cmd;

endmodule

// File: tb/tb_cd_host_if.sv
module tb_cd_host_if;

    localparam int         CR_NUM     = 4;
    localparam int         IRQ_W      = 16;
    localparam int         FIFO_DEPTH = 16;
    localparam logic [9:0] BASE_HI    = 10'h189;
    localparam int         CW         = $clog2(FIFO_DEPTH) + 1;

    logic                   CLK = 1'b0;
    logic                   RST_N, CE_R, ACS2_N;
    logic [25:1]            AA;
    logic [15:0]            ADO, ADI;
    logic                   AWRL_N, AWRU_N, ARD_N, IRQ_N;
    logic                   CMD_VALID, CMD_ACK, RSP_VALID;
    logic [16*CR_NUM-1:0]   CMD_CR, RSP_CR;
    logic [IRQ_W-1:0]       HIRQ_SET;
    logic                   DT_WR, DT_FULL;
    logic [15:0]            DT_DATA;
    logic [CW-1:0]          DT_COUNT;

    always #5 CLK = ~CLK;

    cd_host_if #(
        .CR_NUM(CR_NUM), .IRQ_W(IRQ_W), .FIFO_DEPTH(FIFO_DEPTH), .BASE_HI(BASE_HI)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .ACS2_N(ACS2_N), .AA(AA), .ADO(ADO),
        .ADI(ADI), .AWRL_N(AWRL_N), .AWRU_N(AWRU_N), .ARD_N(ARD_N), .IRQ_N(IRQ_N),
        .CMD_VALID(CMD_VALID), .CMD_CR(CMD_CR), .CMD_ACK(CMD_ACK),
        .RSP_VALID(RSP_VALID), .RSP_CR(RSP_CR), .HIRQ_SET(HIRQ_SET),
        .DT_WR(DT_WR), .DT_DATA(DT_DATA), .DT_FULL(DT_FULL), .DT_COUNT(DT_COUNT)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    logic [15:0] m_hirq, m_mask;
    logic [15:0] m_rsp    [CR_NUM];
    logic [15:0] m_shadow [CR_NUM];
    logic [15:0] m_cmd    [CR_NUM];
    logic        m_cmd_valid;
    logic [15:0] m_q [$];

    int   cmd_rises = 0;
    logic cv_prev   = 1'b0;

    always @(negedge CLK) begin
        if (CMD_VALID === 1'b1 && cv_prev === 1'b0) cmd_rises++;
        cv_prev = CMD_VALID;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic m_reset();
        m_hirq = 16'hFFFF;
        m_mask = 16'hFFFF;
        m_rsp  = '{16'h0043, 16'h4442, 16'h4C4F, 16'h434B};
        for (int k = 0; k < CR_NUM; k++) begin
            m_shadow[k] = 16'h0;
            m_cmd[k]    = 16'h0;
        end
        m_cmd_valid = 1'b0;
        m_q.delete();
    endtask

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] d,
                                          input logic lo, input logic hi);
        return {hi ? d[15:8] : o[15:8], lo ? d[7:0] : o[7:0]};
    endfunction

    function automatic logic [16*CR_NUM-1:0] m_cmd_vec();
        logic [16*CR_NUM-1:0] v;
        for (int k = 0; k < CR_NUM; k++) v[16*k +: 16] = m_cmd[k];
        return v;
    endfunction

    task automatic m_write(input logic [15:0] ofs, input logic [15:0] d,
                           input logic lo, input logic hi);
        int off;
        int k;
        off = int'(ofs);
        if (off == 8)
            m_hirq = m_hirq & {hi ? d[15:8] : 8'hFF, lo ? d[7:0] : 8'hFF};
        else if (off == 12)
            m_mask = merge(m_mask, d, lo, hi);
        else if (off >= 24 && off < 24 + 4*CR_NUM && (off - 24) % 4 == 0 && !m_cmd_valid) begin
            k = (off - 24) / 4;
            m_shadow[k] = merge(m_shadow[k], d, lo, hi);
            if (k == CR_NUM - 1) begin
                m_cmd       = m_shadow;
                m_cmd_valid = 1'b1;
                m_hirq[0]   = 1'b0;
            end
        end
    endtask

    // ---------------- checking / bus helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [25:1] addr(input logic [15:0] ofs);
        return {BASE_HI, ofs[15:1]};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic peek(input logic [15:0] ofs, output logic [15:0] d);
        ACS2_N = 1'b0;
        AA     = addr(ofs);
        #1;
        d      = ADI;
        ACS2_N = 1'b1;
    endtask

    task automatic check_reg(input string tag, input logic [15:0] ofs, input logic [15:0] exp);
        logic [15:0] d;
        peek(ofs, d);
        check(tag, d, exp);
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < CR_NUM; k++)
            check_reg({tag, "_cr"}, 16'(24 + 4*k), m_rsp[k]);
        check_reg({tag, "_hirq"}, 16'h0008, m_hirq);
        check_reg({tag, "_mask"}, 16'h000C, m_mask);
        check({tag, "_irq_n"},  IRQ_N, ~|(m_hirq & m_mask));
        check({tag, "_cmdv"},   CMD_VALID, m_cmd_valid);
        check({tag, "_cmdcr"},  CMD_CR, m_cmd_vec());
        check({tag, "_count"},  DT_COUNT, m_q.size());
        check({tag, "_full"},   DT_FULL, m_q.size() == FIFO_DEPTH);
    endtask

    task automatic check_fifo(input string tag);
        logic [15:0] d;
        peek(16'h0000, d);
        check({tag, "_head"},  d, (m_q.size() > 0) ? m_q[0] : 16'h0000);
        check({tag, "_count"}, DT_COUNT, m_q.size());
        check({tag, "_full"},  DT_FULL, m_q.size() == FIFO_DEPTH);
    endtask

    // Commit happens on the first edge; HIRQ_SET rides along for that edge only.
    task automatic bus_write(input logic [15:0] ofs, input logic [15:0] d,
                             input logic lo, input logic hi, input int hold,
                             input logic [15:0] set);
        ACS2_N = 1'b0; AA = addr(ofs); ADO = d;
        AWRL_N = !lo;  AWRU_N = !hi;  HIRQ_SET = set;
        tick(1);
        m_write(ofs, d, lo, hi);
        m_hirq = m_hirq | set;
        HIRQ_SET = '0;
        if (hold > 1) tick(hold - 1);
        AWRL_N = 1'b1; AWRU_N = 1'b1; ACS2_N = 1'b1;
        tick(1);
    endtask

    task automatic dt_push(input logic [15:0] d);
        DT_WR = 1'b1; DT_DATA = d;
        tick(1);
        DT_WR = 1'b0;
        if (m_q.size() < FIFO_DEPTH) m_q.push_back(d);
    endtask

    // One DTR read access; an optional push lands on the pop edge.
    task automatic dtr_read(input int hold, input logic push, input logic [15:0] pd);
        ACS2_N = 1'b0; AA = addr(16'h0000); ARD_N = 1'b0;
        tick(hold);
        check("dtr_data", ADI, (m_q.size() > 0) ? m_q[0] : 16'h0000);
        ARD_N = 1'b1; DT_WR = push; DT_DATA = pd;
        tick(1);
        DT_WR = 1'b0; ACS2_N = 1'b1;
        if (m_q.size() > 0) void'(m_q.pop_front());
        if (push && m_q.size() < FIFO_DEPTH) m_q.push_back(pd);
        check("dtr_count", DT_COUNT, m_q.size());
        check("dtr_full",  DT_FULL, m_q.size() == FIFO_DEPTH);
    endtask

    task automatic ack();
        CMD_ACK = 1'b1;
        tick(1);
        CMD_ACK = 1'b0;
        m_cmd_valid = 1'b0;
        tick(1);
    endtask

    task automatic load_rsp(input logic [16*CR_NUM-1:0] v);
        RSP_CR = v; RSP_VALID = 1'b1;
        tick(1);
        RSP_VALID = 1'b0;
        for (int k = 0; k < CR_NUM; k++) m_rsp[k] = v[16*k +: 16];
        m_hirq[0] = 1'b1;
        tick(1);
    endtask

    // ---------------- directed + randomized sequence ----------------
    initial begin
        logic [15:0] d;
        logic [1:0]  ln;
        logic [15:0] o;
        int          op;
        int          n0;

        RST_N = 1'b0; CE_R = 1'b0; ACS2_N = 1'b1; AA = '0; ADO = '0;
        AWRL_N = 1'b1; AWRU_N = 1'b1; ARD_N = 1'b1; CMD_ACK = 1'b0;
        RSP_VALID = 1'b0; RSP_CR = '0; HIRQ_SET = '0; DT_WR = 1'b0; DT_DATA = '0;
        m_reset();
        tick(3);
        RST_N = 1'b1;
        tick(2);

        // Reset image, no CE activity yet.
        check_all("rst");
        check_reg("rst_cr1_lit", 16'h0018, 16'h0043);
        check_reg("rst_cr4_lit", 16'h0024, 16'h434B);
        check_reg("unmapped_rd", 16'h0004, 16'h0000);
        CE_R = 1'b1;
        tick(2);

        // Mask + lane-qualified HIRQ clear.
        bus_write(16'h000C, 16'h0001, 1'b1, 1'b1, 2, 16'h0);
        bus_write(16'h0008, 16'hFFFE, 1'b1, 1'b0, 2, 16'h0);
        check_reg("hirq_clr", 16'h0008, 16'hFFFE);
        check("irq_n_masked", IRQ_N, 1'b1);
        // Set wins over a concurrent clear.
        bus_write(16'h0008, 16'h0000, 1'b1, 1'b0, 1, 16'h0001);
        check_reg("hirq_setwin", 16'h0008, 16'hFF01);
        check("irq_n_setwin", IRQ_N, 1'b0);

        // Random HIRQ/HIRQMASK traffic.
        for (int it = 0; it < 24; it++) begin
            ln = 2'($urandom_range(1, 3));
            op = $urandom_range(0, 2);
            if (op == 0)
                bus_write(16'h0008, 16'($urandom), ln[0], ln[1], 1, 16'($urandom) & 16'($urandom));
            else if (op == 1)
                bus_write(16'h000C, 16'($urandom), ln[0], ln[1], $urandom_range(1, 3), 16'h0);
            else begin
                HIRQ_SET = 16'($urandom) & 16'($urandom);
                tick(1);
                m_hirq = m_hirq | HIRQ_SET;
                HIRQ_SET = '0;
                tick(1);
            end
            check_reg("rnd_hirq", 16'h0008, m_hirq);
            check_reg("rnd_mask", 16'h000C, m_mask);
            check("rnd_irq_n", IRQ_N, ~|(m_hirq & m_mask));
        end

        // Command handshake.
        HIRQ_SET = '1;
        tick(1);
        HIRQ_SET = '0;
        m_hirq = 16'hFFFF;
        tick(1);
        n0 = cmd_rises;
        bus_write(16'h0018, 16'h0100, 1'b1, 1'b1, 5, 16'h0);
        check("cmd_partial", CMD_VALID, 1'b0);
        bus_write(16'h001C, 16'h0000, 1'b1, 1'b1, 5, 16'h0);
        bus_write(16'h0020, 16'h0000, 1'b1, 1'b1, 5, 16'h0);
        bus_write(16'h0024, 16'h0040, 1'b1, 1'b1, 5, 16'h0);
        check("cmd_once",  cmd_rises - n0, 1);
        check("cmd_valid", CMD_VALID, 1'b1);
        check("cmd_cr",    CMD_CR, 64'h0040_0000_0000_0100);
        check_reg("cmok_clr", 16'h0008, 16'hFFFE);
        bus_write(16'h0018, 16'hBEEF, 1'b1, 1'b1, 2, 16'h0);
        check("cmd_drop", CMD_CR, 64'h0040_0000_0000_0100);
        ack();
        check("cmd_ack", CMD_VALID, 1'b0);
        load_rsp(64'h4444_3333_2222_1111);
        check_reg("rsp_cr1", 16'h0018, 16'h1111);
        check_reg("rsp_cr4", 16'h0024, 16'h4444);
        check_reg("cmok_set", 16'h0008, 16'hFFFF);
        bus_write(16'h0024, 16'h0055, 1'b1, 1'b1, 1, 16'h0);
        check("cmd_shadow_kept", CMD_CR, 64'h0055_0000_0000_0100);
        ack();

        // Random command register traffic.
        for (int it = 0; it < 16; it++) begin
            ln = 2'($urandom_range(1, 3));
            op = $urandom_range(0, 5);
            if (op == 5)      o = (it % 2 == 1) ? 16'h001A : 16'h0004;
            else if (op == 4) o = 16'(24 + 4*(CR_NUM - 1));
            else              o = 16'(24 + 4*$urandom_range(0, CR_NUM - 1));
            bus_write(o, 16'($urandom), ln[0], ln[1], $urandom_range(1, 3), 16'h0);
            check("rnd_cmdv",  CMD_VALID, m_cmd_valid);
            check("rnd_cmdcr", CMD_CR, m_cmd_vec());
            check_reg("rnd_cmok", 16'h0008, m_hirq);
            if (m_cmd_valid && $urandom_range(0, 1) == 1) ack();
            if ($urandom_range(0, 3) == 0) begin
                load_rsp({32'($urandom), 32'($urandom)});
                check_all("rnd_rsp");
            end
        end
        if (m_cmd_valid) ack();

        // FIFO fill / overflow / drain / underflow.
        check_fifo("fifo_empty");
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            dt_push(16'(16'hA000 + i));
            if (i == 0) check_fifo("fifo_first");
        end
        check("fifo_full_lit",  DT_FULL, 1'b1);
        check("fifo_count_lit", DT_COUNT, FIFO_DEPTH);
        dt_push(16'hDEAD);
        check_fifo("fifo_ovf");
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            dtr_read(4, 1'b0, 16'h0);
            check("drain_lit", DT_COUNT, FIFO_DEPTH - 1 - i);
        end
        dtr_read(4, 1'b0, 16'h0);
        check("underflow_cnt", DT_COUNT, 0);

        // Push + pop together when full, then when empty.
        for (int i = 0; i < FIFO_DEPTH; i++) dt_push(16'(16'hB000 + i));
        dtr_read(3, 1'b1, 16'hC0DE);
        check("full_pp_cnt", DT_COUNT, FIFO_DEPTH);
        for (int i = 0; i < FIFO_DEPTH - 1; i++) dtr_read(2, 1'b0, 16'h0);
        check_reg("full_pp_last", 16'h0000, 16'hC0DE);
        dtr_read(2, 1'b0, 16'h0);
        dtr_read(2, 1'b1, 16'h1234);
        check("empty_pp_cnt", DT_COUNT, 1);
        check_fifo("empty_pp");

        // Random FIFO traffic.
        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(0, 3);
            if (op <= 1)      dt_push(16'($urandom));
            else if (op == 2) dtr_read($urandom_range(1, 3), 1'($urandom_range(0, 1)), 16'($urandom));
            else              tick(1);
            check_fifo("rnd_fifo");
        end

        // Nothing moves without CE_R.
        bus_write(16'h0008, 16'h0000, 1'b1, 1'b1, 1, 16'h0);
        CE_R = 1'b0;
        ACS2_N = 1'b0; AA = addr(16'h000C); ADO = 16'h0000; AWRL_N = 1'b0; AWRU_N = 1'b0;
        HIRQ_SET = '1; DT_WR = 1'b1; DT_DATA = 16'h5A5A; RSP_VALID = 1'b1; RSP_CR = '0;
        tick(3);
        AWRL_N = 1'b1; AWRU_N = 1'b1; ACS2_N = 1'b1;
        HIRQ_SET = '0; DT_WR = 1'b0; RSP_VALID = 1'b0;
        tick(1);
        CE_R = 1'b1;
        tick(2);
        check_all("ce_hold");

        // Reset in the middle of a CR4 write.
        bus_write(16'h0018, 16'h1111, 1'b1, 1'b1, 1, 16'h0);
        bus_write(16'h001C, 16'h2222, 1'b1, 1'b1, 1, 16'h0);
        bus_write(16'h000C, 16'h00F0, 1'b1, 1'b1, 1, 16'h0);
        dt_push(16'h7777);
        n0 = cmd_rises;
        CE_R = 1'b0;
        ACS2_N = 1'b0; AA = addr(16'h0024); ADO = 16'h0099; AWRL_N = 1'b0; AWRU_N = 1'b0;
        tick(2);
        RST_N = 1'b0;
        #1;
        check("rst_imm_cmdv",  CMD_VALID, 1'b0);
        check("rst_imm_count", DT_COUNT, 0);
        check("rst_imm_irq_n", IRQ_N, 1'b0);
        CE_R = 1'b1;
        tick(2);
        RST_N = 1'b1;
        tick(4);
        check("rst_hold_cmdv", CMD_VALID, 1'b0);
        AWRL_N = 1'b1; AWRU_N = 1'b1; ACS2_N = 1'b1;
        tick(2);
        m_reset();
        check_all("post_rst");
        check("post_rst_nocmd", cmd_rises - n0, 0);
        bus_write(16'h0024, 16'h0007, 1'b1, 1'b1, 1, 16'h0);
        check("post_rst_shadow", CMD_CR, 64'h0007_0000_0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
